// File: rtl/motor_dir_pkg.sv
// Shared definitions for the H-bridge direction controller.
// Covers the mode encoding, the per-channel state encoding and the reversal test.
package motor_dir_pkg;

   localparam logic [1:0] MODE_COAST = 2'b00;
   localparam logic [1:0] MODE_FWD   = 2'b10;
   localparam logic [1:0] MODE_REV   = 2'b01;
   localparam logic [1:0] MODE_BRAKE = 2'b11;

   typedef enum logic {
      ST_DRIVE = 1'b0,
      ST_DEAD  = 1'b1
   } state_e;

   // A reversal is a direct FWD<->REV move, the only change that needs dead-time.
   function automatic logic isReversal(input logic [1:0] cur, input logic [1:0] req);
      return ((cur == MODE_FWD) && (req == MODE_REV)) ||
             ((cur == MODE_REV) && (req == MODE_FWD));
   endfunction

endpackage

// File: rtl/motor_dir_ch.sv
// One H-bridge channel: applies mode requests and inserts a coast dead-time
// on every direct forward/reverse reversal.
module motor_dir_ch
   import motor_dir_pkg::*;
#(
   parameter int DEAD_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] mode,
   output logic       dir_out1,
   output logic       dir_out2,
   output logic       busy
);

   localparam int CNT_W = $clog2(DEAD_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYC - 1);

   state_e           state_q, state_d;
   logic [1:0]       cur_q, cur_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_DRIVE;
         cur_q   <= MODE_COAST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter is loaded with DEAD_CYC-1 on entry so coast lasts exactly DEAD_CYC cycles.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         state_d = ST_DRIVE;
         cur_d   = MODE_COAST;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_DRIVE: begin
               if (mode != cur_q) begin
                  if (isReversal(cur_q, mode)) begin
                     state_d = ST_DEAD;
                     cur_d   = MODE_COAST;
                     cnt_d   = CNT_LOAD;
                  end else begin
                     cur_d = mode;
                  end
               end
            end
            ST_DEAD: begin
               if ((mode == MODE_COAST) || (mode == MODE_BRAKE) || (cnt_q == '0)) begin
                  state_d = ST_DRIVE;
                  cur_d   = mode;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_DRIVE;
               cur_d   = MODE_COAST;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      dir_out1 = cur_q[1];
      dir_out2 = cur_q[0];
      busy     = (state_q == ST_DEAD);
   end

endmodule

// File: rtl/motor_dir_ctrl.sv
// Multi-channel H-bridge direction controller: one independent channel
// (FSM plus its own dead-time counter) per motor driver.
module motor_dir_ctrl
   import motor_dir_pkg::*;
#(
   parameter int N_CH     = 2,
   parameter int DEAD_CYC = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [2*N_CH-1:0] mode,
   output logic [N_CH-1:0]   dir_out1,
   output logic [N_CH-1:0]   dir_out2,
   output logic [N_CH-1:0]   busy
);

   for (genvar i = 0; i < N_CH; i++) begin : gCh
      motor_dir_ch #(
         .DEAD_CYC(DEAD_CYC)
      ) uCh (
         .clk     (clk),
         .rst     (rst),
         .enable  (enable),
         .mode    (mode[2*i +: 2]),
         .dir_out1(dir_out1[i]),
         .dir_out2(dir_out2[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_motor_dir_ctrl.sv
// Directed scoreboard bench for motor_dir_ctrl: a DEAD_CYC=4 instance for the
// main sequence and a DEAD_CYC=1 instance for the shortest dead-time.
module tb_motor_dir_ctrl;

   localparam logic [1:0] CO = 2'b00;
   localparam logic [1:0] FW = 2'b10;
   localparam logic [1:0] RV = 2'b01;
   localparam logic [1:0] BR = 2'b11;

   typedef struct {
      string      tag;
      bit         sel;
      logic [5:0] value;
   } expect_t;

   logic       clock;
   logic       reset;
   logic       enableA;
   logic [3:0] modeA;
   logic [1:0] out1A, out2A, busyA;
   logic       enableB;
   logic [3:0] modeB;
   logic [1:0] out1B, out2B, busyB;

   expect_t expQueue[$];
   int      checks = 0;
   int      errors = 0;

   motor_dir_ctrl #(.N_CH(2), .DEAD_CYC(4)) dutA (
      .clk     (clock),
      .rst     (reset),
      .enable  (enableA),
      .mode    (modeA),
      .dir_out1(out1A),
      .dir_out2(out2A),
      .busy    (busyA)
   );

   motor_dir_ctrl #(.N_CH(2), .DEAD_CYC(1)) dutB (
      .clk     (clock),
      .rst     (reset),
      .enable  (enableB),
      .mode    (modeB),
      .dir_out1(out1B),
      .dir_out2(out2B),
      .busy    (busyB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected per-channel applied modes are packed as {dir_out1, dir_out2, busy}.
   function automatic logic [5:0] packExp(input logic [1:0] e1, input logic [1:0] e0,
                                          input logic [1:0] b);
      return {e1[1], e0[1], e1[0], e0[0], b};
   endfunction

   task automatic pushExp(input string tag, input bit sel, input logic [1:0] e1,
                          input logic [1:0] e0, input logic [1:0] b);
      expect_t e;
      e.tag   = tag;
      e.sel   = sel;
      e.value = packExp(e1, e0, b);
      expQueue.push_back(e);
   endtask

   task automatic checkOutput();
      expect_t    e;
      logic [5:0] obs;
      checks++;
      if (expQueue.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard-empty observed none required entry");
      end else begin
         e   = expQueue.pop_front();
         obs = e.sel ? {out1B, out2B, busyB} : {out1A, out2A, busyA};
         assert (obs === e.value) else begin
            errors++;
            $error("[TB] FAIL %s observed %b required %b", e.tag, obs, e.value);
         end
      end
   endtask

   // Drives one request on dutA, records the expected post-edge state and checks it.
   task automatic applyStimulus(input string tag, input logic en, input logic [1:0] m1,
                                input logic [1:0] m0, input logic [1:0] e1,
                                input logic [1:0] e0, input logic [1:0] b);
      enableA = en;
      modeA   = {m1, m0};
      pushExp(tag, 1'b0, e1, e0, b);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   task automatic applyStimulusB(input string tag, input logic [1:0] m0,
                                 input logic [1:0] e0, input logic [1:0] b);
      modeB = {CO, m0};
      pushExp(tag, 1'b1, CO, e0, b);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   initial begin
      reset   = 1'b1;
      enableA = 1'b1;
      modeA   = {FW, FW};
      enableB = 1'b1;
      modeB   = {CO, CO};
      repeat (2) @(posedge clock);
      #1;
      pushExp("reset-A", 1'b0, CO, CO, 2'b00);
      checkOutput();
      pushExp("reset-B", 1'b1, CO, CO, 2'b00);
      checkOutput();
      reset = 1'b0;

      applyStimulus("post-reset-fwd", 1'b1, FW, FW, FW, FW, 2'b00);

      applyStimulus("ch0-coast", 1'b1, FW, CO, FW, CO, 2'b00);
      applyStimulus("ch0-fwd", 1'b1, FW, FW, FW, FW, 2'b00);
      applyStimulus("ch0-brake", 1'b1, FW, BR, FW, BR, 2'b00);
      applyStimulus("ch0-brake-hold", 1'b1, FW, BR, FW, BR, 2'b00);

      applyStimulus("ch0-brake-to-fwd", 1'b1, FW, FW, FW, FW, 2'b00);
      applyStimulus("rev-dead1", 1'b1, FW, RV, FW, CO, 2'b01);
      applyStimulus("rev-dead2", 1'b1, FW, RV, FW, CO, 2'b01);
      applyStimulus("rev-dead3", 1'b1, FW, RV, FW, CO, 2'b01);
      applyStimulus("rev-dead4", 1'b1, FW, RV, FW, CO, 2'b01);
      applyStimulus("rev-applied", 1'b1, FW, RV, FW, RV, 2'b00);

      applyStimulus("brk-dead1", 1'b1, FW, FW, FW, CO, 2'b01);
      applyStimulus("brk-dead2", 1'b1, FW, FW, FW, CO, 2'b01);
      applyStimulus("brk-abort", 1'b1, FW, BR, FW, BR, 2'b00);
      applyStimulus("brk-to-fwd", 1'b1, FW, FW, FW, FW, 2'b00);

      applyStimulus("en-dead1", 1'b1, FW, RV, FW, CO, 2'b01);
      applyStimulus("en-dead2", 1'b1, FW, RV, FW, CO, 2'b01);
      applyStimulus("en-off", 1'b0, FW, RV, CO, CO, 2'b00);
      applyStimulus("en-off-ignored", 1'b0, RV, FW, CO, CO, 2'b00);
      applyStimulus("en-on", 1'b1, FW, RV, FW, RV, 2'b00);

      applyStimulus("rst-dead1", 1'b1, FW, FW, FW, CO, 2'b01);
      applyStimulus("rst-dead2", 1'b1, FW, FW, FW, CO, 2'b01);
      reset = 1'b1;
      #2;
      pushExp("rst-mid-dead", 1'b0, CO, CO, 2'b00);
      checkOutput();
      reset = 1'b0;
      applyStimulus("rst-no-residual", 1'b1, FW, FW, FW, FW, 2'b00);

      // Staggered reversals show each channel keeps its own count.
      applyStimulus("ind-ch1-dead1", 1'b1, RV, FW, CO, FW, 2'b10);
      applyStimulus("ind-both-dead", 1'b1, RV, RV, CO, CO, 2'b11);
      applyStimulus("ind-both-dead2", 1'b1, RV, RV, CO, CO, 2'b11);
      applyStimulus("ind-both-dead3", 1'b1, RV, RV, CO, CO, 2'b11);
      applyStimulus("ind-ch1-done", 1'b1, RV, RV, RV, CO, 2'b01);
      applyStimulus("ind-ch0-done", 1'b1, RV, RV, RV, RV, 2'b00);

      applyStimulusB("b-fwd", FW, FW, 2'b00);
      applyStimulusB("b-dead1", RV, CO, 2'b01);
      applyStimulusB("b-rev", RV, RV, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
